alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: DATA_W, 8, datapath width; only 8 is supported, matching the ALU operand width.
REQ-002 iClock  in  1  sole clock; all state changes on rising edge.
REQ-003 iReset  in  1  synchronous, active-low reset; sampled on rising iClock.
REQ-004 iStart  in  1  request to run one ALU instruction; sampled only while oBusy=0.
REQ-005 iOpcode  in  4  operation code, sampled with iStart.
REQ-006 iOperand  in  8  second-operand data (B/C register or immediate), valid when iOperandValid=1.
REQ-007 iOperandValid  in  1  operand handshake valid.
REQ-008 iALU  in  8  combinational ALU result.
REQ-009 oOperandReq  out  1  operand request, held until the handshake completes.
REQ-010 oA / oTMP  out  8 each  accumulator and TMP registers, driving ALU iA/iB.
REQ-011 oAdd, oSub, oAND, oOR, oXOR, oInc, oDec, oRotateLeft, oRotateRight  out  1 each  ALU controls; at most one high per cycle.
REQ-012 oBusy  out  1  high in every state except IDLE.
REQ-013 oDone  out  1  one-cycle pulse on completion.
REQ-014 oError  out  1  one-cycle pulse on illegal opcode.

Function
REQ-015 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INC, 6 DEC, 7 RAL, 8 RAR, 9 LDA (oA<=operand, ALU unused), 10-15 illegal.
REQ-016 FSM states: IDLE, FETCH, EXEC, DONE.
REQ-017 IDLE, iStart=1: latch opcode; legal two-operand ops (0-4, 9) -> FETCH; unary ops (5-8) -> EXEC; illegal -> IDLE with oError=1 next cycle.
REQ-018 FETCH: oOperandReq=1; on iOperandValid=1, TMP<=iOperand (LDA: oA<=iOperand and go to DONE) -> EXEC; otherwise remain in FETCH indefinitely.
REQ-019 EXEC lasts exactly one cycle: assert only the opcode's control output; at the closing edge oA<=iALU -> DONE.
REQ-020 DONE: oDone=1 for one cycle, all controls 0 -> IDLE.
REQ-021 Latency, unary op: iStart at edge N; EXEC during cycle N+1; oA updated and oDone high in cycle N+2; oBusy=0 in cycle N+3.
REQ-022 Latency, two-operand op: two cycles beyond the edge sampling iOperandValid.
REQ-023 iStart while oBusy=1 is ignored, not queued.
REQ-024 iOperandValid outside FETCH is ignored.
REQ-025 oA/oTMP wrap modulo 256; overflow and carry are not captured.
REQ-026 ALU control outputs are registered from FSM state and are glitch-free; the ALU's zero/sign flag registers update on the EXEC closing edge.

Reset
REQ-027 iReset=0 at a rising edge forces IDLE; oA, oTMP, and latched opcode = 0; all outputs 0.
REQ-028 Reset in any state, including mid-FETCH or EXEC, aborts without oDone or oError and without writing oA.

Configuration
REQ-029 ALU_SEQ_ROTATE_EN defined: opcodes 7/8 are legal and drive oRotateLeft/oRotateRight.
REQ-030 ALU_SEQ_ROTATE_EN undefined: opcodes 7/8 are illegal (oError pulse); oRotateLeft/oRotateRight are tied to 0.

Structure
REQ-031 A shared package holds the opcode constants, the FSM state encoding, and DATA_W.
REQ-032 One sub-module, alu_op_decode, maps opcode to the one-hot control vector plus needs_operand and illegal flags; all sequential logic stays in alu_sequencer.

Verification
REQ-033 Reset, A=0x05, ADD opcode 0, operand 0x03 after 2-cycle valid delay -> oOperandReq held 2 cycles, oAdd high 1 cycle, oA=0x08, single oDone.
REQ-034 A=0x00, DEC opcode 6 -> no operand request, oDec 1 cycle, oA=0xFF, oDone at cycle N+2.
REQ-035 Opcode 12 -> oError pulse 1 cycle, oBusy never set, oA unchanged.
REQ-036 iReset=0 during FETCH of SUB -> IDLE next cycle, no oDone, oA unchanged; new iStart accepted immediately after.
REQ-037 A=0x81, RAL with macro -> oA=0x03; same stimulus without macro -> oError, oRotateLeft never high.
REQ-038 Back-to-back: iStart held high across an INC -> second INC begins only after IDLE; INC from 0xFF wraps to 0x00; at most one control high every cycle.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU sequencer: datapath width, opcodes, control indices, FSM states.
// Optional rotate support is selected by ALU_SEQ_ROTATE_EN (see alu_op_decode).
package alu_sequencer_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned OP_W   = 4;

   localparam logic [OP_W-1:0] OP_ADD = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB = 4'd1;
   localparam logic [OP_W-1:0] OP_AND = 4'd2;
   localparam logic [OP_W-1:0] OP_OR  = 4'd3;
   localparam logic [OP_W-1:0] OP_XOR = 4'd4;
   localparam logic [OP_W-1:0] OP_INC = 4'd5;
   localparam logic [OP_W-1:0] OP_DEC = 4'd6;
   localparam logic [OP_W-1:0] OP_RAL = 4'd7;
   localparam logic [OP_W-1:0] OP_RAR = 4'd8;
   localparam logic [OP_W-1:0] OP_LDA = 4'd9;

   // Bit positions in the one-hot ALU control vector
   localparam int unsigned CTL_ADD = 0;
   localparam int unsigned CTL_SUB = 1;
   localparam int unsigned CTL_AND = 2;
   localparam int unsigned CTL_OR  = 3;
   localparam int unsigned CTL_XOR = 4;
   localparam int unsigned CTL_INC = 5;
   localparam int unsigned CTL_DEC = 6;
   localparam int unsigned CTL_RAL = 7;
   localparam int unsigned CTL_RAR = 8;
   localparam int unsigned N_CTL   = 9;

   typedef logic [N_CTL-1:0] ctrl_t;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StExec,
      StDone
   } state_e;

   function automatic logic is_two_operand(input logic [OP_W-1:0] op);
      return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDA};
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Opcode decoder: one-hot ALU control vector plus needs_operand / illegal flags.
// With ALU_SEQ_ROTATE_EN undefined, RAL/RAR decode as illegal and never drive rotate controls.
module alu_op_decode
   import alu_sequencer_pkg::*;
(
   input  logic [OP_W-1:0] opcode,
   output ctrl_t           ctrl,
   output logic            needs_operand,
   output logic            illegal
);

   always_comb begin
      ctrl          = '0;
      needs_operand = is_two_operand(opcode);
      illegal       = 1'b0;
      case (opcode)
         OP_ADD: ctrl[CTL_ADD] = 1'b1;
         OP_SUB: ctrl[CTL_SUB] = 1'b1;
         OP_AND: ctrl[CTL_AND] = 1'b1;
         OP_OR:  ctrl[CTL_OR]  = 1'b1;
         OP_XOR: ctrl[CTL_XOR] = 1'b1;
         OP_INC: ctrl[CTL_INC] = 1'b1;
         OP_DEC: ctrl[CTL_DEC] = 1'b1;
`ifdef ALU_SEQ_ROTATE_EN
         OP_RAL: ctrl[CTL_RAL] = 1'b1;
         OP_RAR: ctrl[CTL_RAR] = 1'b1;
`else
         OP_RAL: illegal = 1'b1;
         OP_RAR: illegal = 1'b1;
`endif
         OP_LDA: ctrl = '0; // loads A directly; ALU not used
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU instruction: operand fetch handshake, one-cycle execute, done/error pulses.
// Rotate opcodes are legal only when ALU_SEQ_ROTATE_EN is defined.
module alu_sequencer #(
   parameter int unsigned DATA_W = alu_sequencer_pkg::DATA_W
) (
   input  logic              iClock,
   input  logic              iReset,
   input  logic              iStart,
   input  logic [3:0]        iOpcode,
   input  logic [DATA_W-1:0] iOperand,
   input  logic              iOperandValid,
   input  logic [DATA_W-1:0] iALU,
   output logic              oOperandReq,
   output logic [DATA_W-1:0] oA,
   output logic [DATA_W-1:0] oTMP,
   output logic              oAdd,
   output logic              oSub,
   output logic              oAND,
   output logic              oOR,
   output logic              oXOR,
   output logic              oInc,
   output logic              oDec,
   output logic              oRotateLeft,
   output logic              oRotateRight,
   output logic              oBusy,
   output logic              oDone,
   output logic              oError
);

   import alu_sequencer_pkg::*;

   state_e            state_q;
   logic [OP_W-1:0]   opcode_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] tmp_q;
   ctrl_t             ctrl_q;
   logic              busy_q;
   logic              req_q;
   logic              done_q;
   logic              error_q;

   logic [OP_W-1:0]   dec_opcode;
   ctrl_t             dec_ctrl;
   logic              dec_needs_operand;
   logic              dec_illegal;

   // Decode the incoming opcode while idle, the latched one afterwards
   assign dec_opcode = (state_q == StIdle) ? iOpcode : opcode_q;

   alu_op_decode u_decode (
      .opcode        (dec_opcode),
      .ctrl          (dec_ctrl),
      .needs_operand (dec_needs_operand),
      .illegal       (dec_illegal)
   );

   always_ff @(posedge iClock) begin
      if (!iReset) begin
         state_q  <= StIdle;
         opcode_q <= '0;
         a_q      <= '0;
         tmp_q    <= '0;
         ctrl_q   <= '0;
         busy_q   <= 1'b0;
         req_q    <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         ctrl_q  <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (iStart) begin
                  opcode_q <= iOpcode;
                  if (dec_illegal) begin
                     error_q <= 1'b1;
                  end else if (dec_needs_operand) begin
                     state_q <= StFetch;
                     busy_q  <= 1'b1;
                     req_q   <= 1'b1;
                  end else begin
                     state_q <= StExec;
                     busy_q  <= 1'b1;
                     ctrl_q  <= dec_ctrl;
                  end
               end
            end
            StFetch: begin
               if (iOperandValid) begin
                  req_q <= 1'b0;
                  if (opcode_q == OP_LDA) begin
                     a_q     <= iOperand;
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     tmp_q   <= iOperand;
                     state_q <= StExec;
                     ctrl_q  <= dec_ctrl;
                  end
               end
            end
            StExec: begin
               a_q     <= iALU;
               state_q <= StDone;
               done_q  <= 1'b1;
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign oA           = a_q;
   assign oTMP         = tmp_q;
   assign oOperandReq  = req_q;
   assign oBusy        = busy_q;
   assign oDone        = done_q;
   assign oError       = error_q;
   assign oAdd         = ctrl_q[CTL_ADD];
   assign oSub         = ctrl_q[CTL_SUB];
   assign oAND         = ctrl_q[CTL_AND];
   assign oOR          = ctrl_q[CTL_OR];
   assign oXOR         = ctrl_q[CTL_XOR];
   assign oInc         = ctrl_q[CTL_INC];
   assign oDec         = ctrl_q[CTL_DEC];
   assign oRotateLeft  = ctrl_q[CTL_RAL];
   assign oRotateRight = ctrl_q[CTL_RAR];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus random instructions
// against an instruction-level reference model; follows ALU_SEQ_ROTATE_EN like the DUT.
module tb_alu_sequencer;

   logic       clk;
   logic       iReset;
   logic       iStart;
   logic [3:0] iOpcode;
   logic [7:0] iOperand;
   logic       iOperandValid;
   logic [7:0] alu_m;
   logic       oOperandReq;
   logic [7:0] oA;
   logic [7:0] oTMP;
   logic       oAdd, oSub, oAND, oOR, oXOR, oInc, oDec, oRotateLeft, oRotateRight;
   logic       oBusy, oDone, oError;
   logic [8:0] ctrl_v;

   int   vectors;
   int   miscompares;
   bit   mon_en;
   logic [7:0] a_m;

   alu_sequencer #(.DATA_W(8)) dut (
      .iClock        (clk),
      .iReset        (iReset),
      .iStart        (iStart),
      .iOpcode       (iOpcode),
      .iOperand      (iOperand),
      .iOperandValid (iOperandValid),
      .iALU          (alu_m),
      .oOperandReq   (oOperandReq),
      .oA            (oA),
      .oTMP          (oTMP),
      .oAdd          (oAdd),
      .oSub          (oSub),
      .oAND          (oAND),
      .oOR           (oOR),
      .oXOR          (oXOR),
      .oInc          (oInc),
      .oDec          (oDec),
      .oRotateLeft   (oRotateLeft),
      .oRotateRight  (oRotateRight),
      .oBusy         (oBusy),
      .oDone         (oDone),
      .oError        (oError)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control vector indexed by opcode number
   assign ctrl_v = {oRotateRight, oRotateLeft, oDec, oInc, oXOR, oOR, oAND, oSub, oAdd};

   // Behavioural combinational ALU
   always_comb begin
      alu_m = oA;
      if (oAdd)              alu_m = oA + oTMP;
      else if (oSub)         alu_m = oA - oTMP;
      else if (oAND)         alu_m = oA & oTMP;
      else if (oOR)          alu_m = oA | oTMP;
      else if (oXOR)         alu_m = oA ^ oTMP;
      else if (oInc)         alu_m = oA + 8'd1;
      else if (oDec)         alu_m = oA - 8'd1;
      else if (oRotateLeft)  alu_m = {oA[6:0], oA[7]};
      else if (oRotateRight) alu_m = {oA[0], oA[7:1]};
   end

   function automatic bit is_legal(input logic [3:0] op);
`ifdef ALU_SEQ_ROTATE_EN
      return op <= 4'd9;
`else
      return (op <= 4'd9) && (op != 4'd7) && (op != 4'd8);
`endif
   endfunction

   function automatic bit needs_op(input logic [3:0] op);
      return (op <= 4'd4) || (op == 4'd9);
   endfunction

   function automatic logic [7:0] ref_a(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a + 8'd1;
         4'd6: return a - 8'd1;
         4'd7: return {a[6:0], a[7]};
         4'd8: return {a[0], a[7:1]};
         4'd9: return b;
         default: return a;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         vectors++;
         assert (($countones(ctrl_v) <= 1) && !$isunknown(ctrl_v))
         else begin
            miscompares++;
            $error("FAIL onehot observed=%b expected=at_most_one_high", ctrl_v);
         end
`ifndef ALU_SEQ_ROTATE_EN
         vectors++;
         assert ({oRotateLeft, oRotateRight} === 2'b00)
         else begin
            miscompares++;
            $error("FAIL rot_tied observed=%b expected=00", {oRotateLeft, oRotateRight});
         end
`endif
      end
   end

   // One instruction: start sampled at the next edge; d = cycles oOperandReq is high
   task automatic run_instr(input logic [3:0] op, input logic [7:0] operand, input int d,
                            input bit hold);
      logic [7:0] a_exp;
      int         reqs;
      iStart  = 1'b1;
      iOpcode = op;
      tick();
      if (!is_legal(op)) begin
         iStart = 1'b0;
         chk("err_pulse", 32'(oError), 32'(1'b1));
         chk("err_busy", 32'(oBusy), 32'(1'b0));
         chk("err_req", 32'(oOperandReq), 32'(1'b0));
         tick();
         chk("err_drop", 32'(oError), 32'(1'b0));
         chk("err_a", 32'(oA), 32'(a_m));
         chk("err_busy2", 32'(oBusy), 32'(1'b0));
         return;
      end
      iStart  = hold ? 1'b1 : 1'($urandom_range(0, 1));
      iOpcode = 4'($urandom);
      if (needs_op(op)) begin
         reqs = 0;
         for (int i = 1; i <= d; i++) begin
            if (oOperandReq === 1'b1) reqs++;
            iOperandValid = (i == d);
            iOperand      = (i == d) ? operand : 8'($urandom);
            tick();
            iStart = hold ? 1'b1 : 1'($urandom_range(0, 1));
         end
         iOperandValid = 1'b0;
         chk("req_cycles", 32'(reqs), 32'(d));
         chk("req_drop", 32'(oOperandReq), 32'(1'b0));
      end
      a_exp = ref_a(op, a_m, operand);
      if (op != 4'd9) begin
         chk("exec_ctrl", 32'(ctrl_v), 32'(9'b1 << op));
         chk("exec_busy", 32'(oBusy), 32'(1'b1));
         chk("exec_done", 32'(oDone), 32'(1'b0));
         if (needs_op(op)) chk("exec_tmp", 32'(oTMP), 32'(operand));
         iOperandValid = 1'($urandom_range(0, 1));
         iOperand      = 8'($urandom);
         tick();
      end
      chk("done_pulse", 32'(oDone), 32'(1'b1));
      chk("done_a", 32'(oA), 32'(a_exp));
      chk("done_ctrl", 32'(ctrl_v), 32'(0));
      chk("done_busy", 32'(oBusy), 32'(1'b1));
      a_m = a_exp;
      iOperandValid = 1'($urandom_range(0, 1));
      iOperand      = 8'($urandom);
      tick();
      iOperandValid = 1'b0;
      iStart        = 1'b0;
      chk("idle_busy", 32'(oBusy), 32'(1'b0));
      chk("idle_done", 32'(oDone), 32'(1'b0));
      chk("idle_a", 32'(oA), 32'(a_m));
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      mon_en        = 1'b0;
      a_m           = 8'h00;
      iReset        = 1'b0;
      iStart        = 1'b0;
      iOpcode       = 4'd0;
      iOperand      = 8'h00;
      iOperandValid = 1'b0;
      tick();
      tick();
      mon_en = 1'b1;
      chk("rst_a", 32'(oA), 32'(0));
      chk("rst_tmp", 32'(oTMP), 32'(0));
      chk("rst_flags", 32'({oBusy, oDone, oError, oOperandReq}), 32'(0));
      chk("rst_ctrl", 32'(ctrl_v), 32'(0));
      iReset = 1'b1;

      // A = 0x05, ADD 0x03 with request held two cycles
      run_instr(4'd9, 8'h05, 1, 1'b0);
      run_instr(4'd0, 8'h03, 2, 1'b0);
      chk("add_a", 32'(oA), 32'(8'h08));
      chk("add_tmp", 32'(oTMP), 32'(8'h03));

      // DEC from zero wraps
      run_instr(4'd9, 8'h00, 3, 1'b0);
      run_instr(4'd6, 8'h00, 0, 1'b0);
      chk("dec_a", 32'(oA), 32'(8'hFF));

      // Illegal opcode
      run_instr(4'd12, 8'h00, 0, 1'b0);

      // Reset mid-FETCH of SUB, then immediate new instruction
      run_instr(4'd9, 8'h00, 1, 1'b0);
      iStart  = 1'b1;
      iOpcode = 4'd1;
      tick();
      iStart = 1'b0;
      chk("fetch_req", 32'(oOperandReq), 32'(1'b1));
      iReset        = 1'b0;
      iOperandValid = 1'b1;
      iOperand      = 8'h77;
      tick();
      iReset        = 1'b1;
      iOperandValid = 1'b0;
      chk("abort_flags", 32'({oBusy, oDone, oError, oOperandReq}), 32'(0));
      chk("abort_a", 32'(oA), 32'(8'h00));
      a_m = 8'h00;
      run_instr(4'd5, 8'h00, 0, 1'b0);
      chk("post_abort_a", 32'(oA), 32'(8'h01));

      // RAL of 0x81 (legal only with rotate enabled)
      run_instr(4'd9, 8'h81, 2, 1'b0);
      run_instr(4'd7, 8'h00, 0, 1'b0);
`ifdef ALU_SEQ_ROTATE_EN
      chk("ral_a", 32'(oA), 32'(8'h03));
`else
      chk("ral_a", 32'(oA), 32'(8'h81));
`endif

      // Back-to-back INC with iStart held through busy
      run_instr(4'd9, 8'hFE, 1, 1'b0);
      run_instr(4'd5, 8'h00, 0, 1'b1);
      run_instr(4'd5, 8'h00, 0, 1'b1);
      chk("inc_wrap", 32'(oA), 32'(8'h00));

      // Random instructions
      for (int n = 0; n < 200; n++) begin
         run_instr(4'($urandom), 8'($urandom), int'($urandom_range(1, 4)),
                   1'($urandom_range(0, 1)));
      end

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
